// File: rtl/rotary_pkg.sv
// Shared types for the rotary step controller: FSM encoding, queued step entry layout
// and direction constants.
package rotary_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_e;

  typedef struct packed {
    logic dir;
    logic fast;
  } step_entry_t;

  localparam int   ENTRY_W  = $bits(step_entry_t);
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/step_fifo.sv
// Small synchronous FIFO for detent steps. A push into a full FIFO is accepted when a pop
// happens on the same edge; flush empties it and wins over push/pop.
module step_fifo #(
  parameter  int DEPTH   = 4,
  parameter  int ENTRY_W = 2,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rotary_step_controller.sv
// Turns detent strobes into a bounded up/down count with acceleration, saturate/wrap
// limits, a queued step buffer, hold and synchronous load/flush.
module rotary_step_controller
  import rotary_pkg::*;
#(
  parameter  int WIDTH       = 10,
  parameter  int MIN_VAL     = 0,
  parameter  int MAX_VAL     = 1023,
  parameter  int FAST_WINDOW = 100,
  parameter  int FAST_STEP   = 8,
  parameter  int FIFO_DEPTH  = 4,
  localparam int PEND_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic              Step,
  input  logic              Dir,
  input  logic              Wrap,
  input  logic              Hold,
  input  logic              Load,
  input  logic [WIDTH-1:0]  Load_Value,
  output logic [WIDTH-1:0]  Count,
  output logic              Changed,
  output logic              Limit,
  output logic              Overflow,
  output logic [PEND_W-1:0] Pending,
  output state_e            Dbg_State
);

  localparam int             IVL_W = $clog2(FAST_WINDOW + 1);
  localparam logic [WIDTH:0] MIN_X = (WIDTH + 1)'(MIN_VAL);
  localparam logic [WIDTH:0] MAX_X = (WIDTH + 1)'(MAX_VAL);

  state_e            state_q, state_d;
  step_entry_t       op_q;
  step_entry_t       fifo_wr;
  step_entry_t       fifo_rd;
  logic [IVL_W-1:0]  interval_q;
  logic              last_dir_q;
  logic              fifo_full, fifo_empty;
  logic              pop, push, drop;

  // Valid/ready: a step is accepted when the queue has room or frees a slot on the same
  // edge; the FSM takes the head only in IDLE with Hold and Load both low.
  assign pop     = (state_q == IDLE) && !fifo_empty && !Hold && !Load;
  assign push    = Step && !Load && (!fifo_full || pop);
  assign drop    = Step && !Load && fifo_full && !pop;
  assign fifo_wr = '{dir: Dir,
                     fast: (interval_q < IVL_W'(FAST_WINDOW)) && (Dir == last_dir_q)};

  assign Dbg_State = state_q;

  step_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Reset_N),
    .push    (push),
    .pop     (pop),
    .flush   (Load),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (Pending)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Load) state_d = IDLE;
  end

  // One extra bit keeps Count+inc and MIN_VAL+inc free of wrap-around.
  logic [WIDTH:0]   cnt_x, inc_x, sum_x, apply_x, load_x;
  logic             apply_limit;
  logic [WIDTH-1:0] count_d;
  logic             limit_d;

  always_comb begin
    cnt_x       = {1'b0, Count};
    inc_x       = op_q.fast ? (WIDTH + 1)'(FAST_STEP) : (WIDTH + 1)'(1);
    sum_x       = cnt_x + inc_x;
    apply_x     = cnt_x;
    apply_limit = 1'b0;
    if (op_q.dir == DIR_UP) begin
      if (sum_x <= MAX_X) begin
        apply_x = sum_x;
      end else begin
        apply_limit = 1'b1;
        apply_x     = Wrap ? MIN_X : MAX_X;
      end
    end else begin
      if (cnt_x >= MIN_X + inc_x) begin
        apply_x = cnt_x - inc_x;
      end else begin
        apply_limit = 1'b1;
        apply_x     = Wrap ? MAX_X : MIN_X;
      end
    end

    load_x = {1'b0, Load_Value};
    if (load_x < MIN_X) load_x = MIN_X;
    if (load_x > MAX_X) load_x = MAX_X;

    count_d = Count;
    limit_d = 1'b0;
    if (Load) begin
      count_d = load_x[WIDTH-1:0];
    end else if (state_q == APPLY) begin
      count_d = apply_x[WIDTH-1:0];
      limit_d = apply_limit;
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q    <= IDLE;
      op_q       <= '0;
      Count      <= WIDTH'(MIN_VAL);
      Changed    <= 1'b0;
      Limit      <= 1'b0;
      Overflow   <= 1'b0;
      interval_q <= IVL_W'(FAST_WINDOW);
      last_dir_q <= DIR_UP;
    end else begin
      state_q <= state_d;
      Count   <= count_d;
      Changed <= (count_d != Count);
      Limit   <= limit_d;
      if (pop) op_q <= fifo_rd;

      if (Load)      Overflow <= 1'b0;
      else if (drop) Overflow <= 1'b1;

      // Spacing is tracked even for steps swallowed by a Load.
      if (Step) begin
        interval_q <= '0;
        last_dir_q <= Dir;
      end else if (interval_q < IVL_W'(FAST_WINDOW)) begin
        interval_q <= interval_q + IVL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rotary_step_controller.sv
// Directed bench for rotary_step_controller: a queue-based reference model checked every
// cycle, plus hand-computed checkpoints for each scenario.
module tb_rotary_step_controller;
  import rotary_pkg::*;

  localparam int WIDTH = 11;
  localparam int MINV  = 0;
  localparam int MAXV  = 1023;
  localparam int FW    = 100;
  localparam int FS    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH + 1);

  logic             Clk = 1'b0;
  logic             Reset_N = 1'b0;
  logic             Step = 1'b0;
  logic             Dir = 1'b1;
  logic             Wrap = 1'b0;
  logic             Hold = 1'b0;
  logic             Load = 1'b0;
  logic [WIDTH-1:0] Load_Value = '0;
  logic [WIDTH-1:0] Count;
  logic             Changed, Limit, Overflow;
  logic [PW-1:0]    Pending;
  state_e           Dbg_State;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  rotary_step_controller #(
    .WIDTH (WIDTH), .MIN_VAL (MINV), .MAX_VAL (MAXV),
    .FAST_WINDOW (FW), .FAST_STEP (FS), .FIFO_DEPTH (DEPTH)
  ) dut (
    .Clk (Clk), .Reset_N (Reset_N), .Step (Step), .Dir (Dir), .Wrap (Wrap),
    .Hold (Hold), .Load (Load), .Load_Value (Load_Value), .Count (Count),
    .Changed (Changed), .Limit (Limit), .Overflow (Overflow), .Pending (Pending),
    .Dbg_State (Dbg_State)
  );

  // ---------------- reference model ----------------
  logic [1:0] exp_q[$];   // queued steps {dir, fast}
  int         m_count;
  bit         m_changed, m_limit, m_ovf, m_busy, m_last_dir;
  logic [1:0] m_op;
  int         m_interval;

  always @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      exp_q.delete();
      m_count = MINV; m_changed = 0; m_limit = 0; m_ovf = 0; m_busy = 0;
      m_interval = FW; m_last_dir = 1; m_op = 2'b00;
    end else begin
      int  old, inc, lv, nv;
      bit  fast;
      old = m_count;
      m_limit = 0;
      fast = (m_interval < FW) && (Dir == m_last_dir);
      if (Load) begin
        lv = int'(Load_Value);
        m_count = (lv < MINV) ? MINV : (lv > MAXV) ? MAXV : lv;
        exp_q.delete();
        m_busy = 0;
        m_ovf = 0;
      end else begin
        if (m_busy) begin
          inc = m_op[0] ? FS : 1;
          nv = m_op[1] ? m_count + inc : m_count - inc;
          if (nv > MAXV) begin m_limit = 1; nv = Wrap ? MINV : MAXV; end
          else if (nv < MINV) begin m_limit = 1; nv = Wrap ? MAXV : MINV; end
          m_count = nv;
          m_busy = 0;
        end else if (exp_q.size() > 0 && !Hold) begin
          m_op = exp_q.pop_front();
          m_busy = 1;
        end
        if (Step) begin
          if (exp_q.size() < DEPTH) exp_q.push_back({Dir, fast});
          else m_ovf = 1;
        end
      end
      m_changed = (m_count != old);
      if (Step) begin m_interval = 0; m_last_dir = Dir; end
      else if (m_interval < FW) m_interval++;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      check("cyc_count",    32'(Count),    32'(m_count));
      check("cyc_changed",  32'(Changed),  32'(m_changed));
      check("cyc_limit",    32'(Limit),    32'(m_limit));
      check("cyc_overflow", 32'(Overflow), 32'(m_ovf));
      check("cyc_pending",  32'(Pending),  32'(exp_q.size()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic do_step(input logic d);
    Step = 1'b1; Dir = d;
    tick();
    Step = 1'b0;
  endtask

  task automatic do_load(input int v);
    Load = 1'b1; Load_Value = WIDTH'(v);
    tick();
    Load = 1'b0;
  endtask

  task automatic settle();
    repeat (FW + 10) tick();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    #1;
    check("rst_count",    32'(Count),    0);
    check("rst_pending",  32'(Pending),  0);
    check("rst_overflow", 32'(Overflow), 0);
    check("rst_changed",  32'(Changed),  0);
    check("rst_limit",    32'(Limit),    0);
    tick();
    Reset_N = 1'b1;
    cmp_en  = 1'b1;
    tick();

    // 1: single up step, two-edge latency
    do_step(1);
    check("t1_pend_e0",  32'(Pending), 1);
    check("t1_count_e0", 32'(Count),   0);
    tick();
    check("t1_pend_e1",  32'(Pending), 0);
    check("t1_count_e1", 32'(Count),   0);
    tick();
    check("t1_count_e2", 32'(Count),   1);
    check("t1_changed",  32'(Changed), 1);
    tick();
    check("t1_changed_off", 32'(Changed), 0);

    // 2: down step at lower bound, saturate then wrap
    do_load(0);
    check("t2_load0", 32'(Count), 0);
    Wrap = 1'b0;
    do_step(0); tick(); tick();
    check("t2_sat_count",   32'(Count),   0);
    check("t2_sat_limit",   32'(Limit),   1);
    check("t2_sat_changed", 32'(Changed), 0);
    Wrap = 1'b1;
    do_step(0); tick(); tick();
    check("t2_wrap_count",   32'(Count),   1023);
    check("t2_wrap_limit",   32'(Limit),   1);
    check("t2_wrap_changed", 32'(Changed), 1);
    Wrap = 1'b0;

    // 3: acceleration window and direction reversal
    do_load(0);
    settle();
    do_step(1); tick(); tick();
    check("t3_first", 32'(Count), 1);
    repeat (7) tick();
    do_step(1); tick(); tick();
    check("t3_fast", 32'(Count), 9);
    repeat (150) tick();
    do_step(1); tick(); tick();
    check("t3_slow", 32'(Count), 10);
    do_step(0); tick(); tick();
    check("t3_reverse", 32'(Count), 9);

    // 4: hold fills queue, overflow, then drain
    do_load(0);
    settle();
    Hold = 1'b1;
    repeat (6) begin
      do_step(1); tick(); tick();
    end
    check("t4_pending",  32'(Pending),  4);
    check("t4_overflow", 32'(Overflow), 1);
    check("t4_count",    32'(Count),    0);
    Hold = 1'b0;
    n = 0;
    repeat (10) begin
      tick();
      if (Changed) n++;
    end
    check("t4_pulses",   n,               4);
    check("t4_final",    32'(Count),      25);
    check("t4_ovf_keep", 32'(Overflow),   1);

    // 5: clamped load flushes; load swallows a coincident step
    Hold = 1'b1;
    repeat (5) do_step(1);
    do_load(2000);
    check("t5_clamp",    32'(Count),    1023);
    check("t5_flush",    32'(Pending),  0);
    check("t5_ovf_clr",  32'(Overflow), 0);
    check("t5_changed",  32'(Changed),  1);
    Load = 1'b1; Load_Value = WIDTH'(5); Step = 1'b1; Dir = 1'b1;
    tick();
    Load = 1'b0; Step = 1'b0;
    check("t5_ls_pend",  32'(Pending),  0);
    check("t5_ls_ovf",   32'(Overflow), 0);
    check("t5_ls_count", 32'(Count),    5);
    Hold = 1'b0;
    repeat (4) tick();
    check("t5_ls_hold",  32'(Count),    5);

    // 6: reset during APPLY
    do_load(500);
    settle();
    do_step(1); tick();
    check("t6_in_apply", 32'(Dbg_State), 32'(APPLY));
    Reset_N = 1'b0;
    #1;
    check("t6_rst_count",   32'(Count),   0);
    check("t6_rst_changed", 32'(Changed), 0);
    check("t6_rst_pending", 32'(Pending), 0);
    tick();
    check("t6_rst_hold", 32'(Count), 0);
    Reset_N = 1'b1;
    tick();
    do_step(1); tick(); tick();
    check("t6_after", 32'(Count), 1);
    repeat (3) tick();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotary_step_controller.md
Name: rotary_step_controller

Overview:
- Sequences detent events from the quadrature decode/event-detect path into a bounded up/down display count.
- Buffers step events in a small FIFO.
- Applies acceleration: fast-spun steps move by a larger increment.
- Supports saturate or wrap limits, a synchronous load/flush, and a hold (pause).
- Sits between the event detector and the LED/count output, clocked in the 2 kHz sample domain.

Parameters:
WIDTH, 10, count width
MIN_VAL, 0, lower count bound
MAX_VAL, 1023, upper count bound (MIN_VAL < MAX_VAL <= 2^WIDTH-1)
FAST_WINDOW, 100, step spacing in Clk cycles below which a step is "fast"
FAST_STEP, 8, increment for fast steps (normal step = 1)
FIFO_DEPTH, 4, step queue depth (power of 2, >= 2)

Ports:
Clk  in  1  sample-domain clock (all logic on rising edge)
Reset_N  in  1  asynchronous, active-low reset
Step  in  1  one-cycle detent event strobe
Dir  in  1  direction qualifying Step: 1 = up, 0 = down
Wrap  in  1  1 = wrap at bounds, 0 = saturate
Hold  in  1  1 = stop dequeuing (queue still fills)
Load  in  1  one-cycle synchronous load/flush strobe
Load_Value  in  WIDTH  value for Load
Count  out  WIDTH  current count
Changed  out  1  one-cycle pulse when Count changes value
Limit  out  1  one-cycle pulse when a step was clamped (Wrap=0) or wrapped (Wrap=1)
Overflow  out  1  sticky: a Step was dropped because the FIFO was full
Pending  out  clog2(FIFO_DEPTH+1)  number of queued steps

Behaviour:
Reset (async, Reset_N=0):
- Count=MIN_VAL; Changed=Limit=Overflow=0; Pending=0.
- FIFO empty; FSM=IDLE; interval counter = FAST_WINDOW (saturated), last_dir=1.
- Reset is effective mid-operation; any in-flight APPLY is discarded.

Enqueue (every edge with Step=1 and Load=0):
- fast = (interval < FAST_WINDOW) && (Dir == last_dir).
- Entry {Dir, fast} is written if the FIFO is not full, or if a pop occurs on the same edge.
- Otherwise the step is dropped and Overflow is set.
- On any Step: interval <= 0, last_dir <= Dir. Otherwise interval increments, saturating at FAST_WINDOW.

FSM states: IDLE, APPLY.
- IDLE: if FIFO not empty and Hold=0 and Load=0 -> pop the head into the op register, go to APPLY. Else stay.
- APPLY: compute the new Count, drive Changed/Limit for one cycle, go to IDLE unconditionally.
  - Hold does not abort an APPLY already in progress.
- Throughput: 1 step per 2 cycles.
- Latency: with an empty FIFO, a Step sampled at edge e0 updates Count at edge e2. Changed is high during the cycle after e2.

Arithmetic (inc = fast ? FAST_STEP : 1; computed at WIDTH+1 bits, no intermediate overflow):
- Up, Count+inc <= MAX_VAL: Count += inc.
- Up, Count+inc > MAX_VAL: Wrap=0 -> MAX_VAL; Wrap=1 -> MIN_VAL. Limit pulses in either case.
- Down, Count-inc >= MIN_VAL: Count -= inc. Compare signed, or as Count >= MIN_VAL+inc.
- Down, Count-inc < MIN_VAL: Wrap=0 -> MIN_VAL; Wrap=1 -> MAX_VAL. Limit pulses.
- Changed pulses only if the new value differs from the old one. A saturated step already at the bound gives Limit=1, Changed=0.

Load (highest priority, synchronous):
- Count <= clamp(Load_Value, MIN_VAL, MAX_VAL).
- Flushes the FIFO; a pending APPLY is cancelled; FSM -> IDLE.
- Overflow cleared; Limit=0.
- Changed pulses if the value differs.
- A Step on the same edge as Load is dropped and does not set Overflow. It does update interval/last_dir.

Pending reflects FIFO occupancy after each edge.

Decomposition:
- Shared package rotary_pkg: FSM state encoding (IDLE, APPLY), FIFO entry layout {dir, fast}, DIR_UP/DIR_DOWN constants.
- Sub-module step_fifo: synchronous FIFO with DEPTH/entry-width parameters.
  - Ports: push, pop, flush, full, empty, count.
  - Simultaneous push+pop when full is allowed.
- Controller FSM, interval counter and arithmetic stay in rotary_step_controller.

Test Plan:
1. Reset, Step Dir=1 at e0 -> Count 0->1 at e2; Changed=1 for one cycle; Pending 1 then 0.
2. Count=0, Wrap=0, Step Dir=0 -> Count stays 0, Limit=1, Changed=0. Repeat with Wrap=1 -> Count=1023, Limit=1, Changed=1.
3. Two Dir=1 steps 10 cycles apart from 0 -> Count 1 then 9. Third step after 150 idle cycles -> 10. A direction reversal within the window -> step of 1.
4. Hold=1, 6 up steps spaced 3 cycles from 0 -> Pending=4, Overflow=1. Release Hold -> Count ends at 25 (1+8+8+8), 4 Changed pulses at 2-cycle spacing.
5. Load with Load_Value=2000 -> Count=1023, FIFO flushed, Overflow cleared. Load and Step on the same edge -> step dropped, Pending=0.
6. Reset_N low mid-APPLY (Count 500 -> 501 in flight) -> Count=0 immediately, no Changed; after release, the next Step gives Count=1 with inc=1 (not fast).
